ibex_data_mem_responder: RTL and testbench
==========================================

Name: ibex_data_mem_responder

Overview:
Synthesizable data-memory slave sitting directly downstream of the LSU data port. It consumes core requests (req/addr/we/be/wdata), issues grants, and returns in-order responses (rvalid/rdata/err) from an internal word array. Grant delay, response latency and outstanding depth are configurable, so the same block can act as the DUT-side memory model and as the reference for the LSU agent's driver/monitor checks.

Parameters:
MEM_WORDS, 1024, depth of word array (power of 2)
BASE_ADDR, 32'h0000_0000, byte address of word 0
GNT_DELAY, 0, cycles req must be held high before gnt asserts (0 = same-cycle grant)
RSP_LATENCY, 1, cycles from grant edge to rvalid (>=1)
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
stall_i  input  1  testbench back-pressure, 1 = suppress grant this cycle
data_req_i  input  1  request valid from core
data_gnt_o  output  1  grant, combinational from req and internal state
data_we_i  input  1  1 = write, 0 = read
data_be_i  input  4  byte enables, bit n = byte lane n
data_addr_i  input  32  byte address, word-aligned (bits [1:0] ignored)
data_wdata_i  input  32  write data
data_rvalid_o  output  1  response valid, one-cycle pulse per transaction
data_rdata_o  output  32  read data, valid with rvalid
data_err_o  output  1  error, valid with rvalid

Behaviour:
- Reset (rst_ni=0, async): rvalid_o=0, rdata_o=0, err_o=0, gnt_o=0, response pipeline cleared, outstanding count=0, wait counter=0. Memory array not reset. In-flight transactions are dropped; no response after reset release.
- Wait counter: increments each cycle req_i=1 and no grant; clears on grant or when req_i=0; saturates at GNT_DELAY.
- Grant: gnt_o = req_i & ~stall_i & (wait_cnt >= GNT_DELAY) & (outstanding < MAX_OUTSTANDING | response retiring this cycle). Transaction accepted on the rising edge where req_i & gnt_o.
- Address decode: idx = (addr - BASE_ADDR) >> 2; in range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS.
- Write accept, in range: byte lanes with be_i[n]=1 updated at the accept edge; be_i=4'b0000 leaves memory unchanged, still responded to. Response rdata=0, err=0.
- Read accept, in range: full word mem[idx] sampled at accept edge (be_i ignored); a read accepted the cycle after a write to the same word returns the written data. Response err=0.
- Out-of-range accept (read or write): no memory update, response rdata=0, err=1.
- Response pipeline: RSP_LATENCY-stage shift register of {valid, rdata, err}; rvalid_o asserts exactly RSP_LATENCY cycles after accept edge, for one cycle; responses strictly in accept order; at most one response per cycle.
- Outstanding count: +1 on accept, -1 on rvalid_o; simultaneous accept and retire leaves count unchanged; never exceeds MAX_OUTSTANDING, never underflows.
- rdata_o/err_o driven 0 whenever rvalid_o=0.
- Back-to-back: with GNT_DELAY=0, MAX_OUTSTANDING>=RSP_LATENCY, stall_i=0, one transaction accepted per cycle.
- req_i dropping before grant: no transaction, wait counter clears.
- Address wrap: addresses beyond array end never alias; they produce err.

Test Plan:
- Defaults; write addr 0x10, wdata 0xDEADBEEF, be 4'hF; then read 0x10 -> write gnt same cycle, rvalid 1 cycle later err=0; read rvalid rdata=0xDEADBEEF.
- Partial write be=4'b0101 wdata 0x11223344 over 0xDEADBEEF at 0x20 -> subsequent read returns 0xDE22BE44.
- GNT_DELAY=3, req held -> gnt asserts in 4th cycle of req; req dropped after 2 cycles then reasserted -> count restarts, no response for dropped request.
- RSP_LATENCY=3, MAX_OUTSTANDING=2, 4 back-to-back reads -> grants on cycles 0,1, then stalled until first rvalid at cycle 3; all 4 rvalids in order, none lost.
- Read addr BASE_ADDR+4*MEM_WORDS (0x1000) -> rvalid with err=1, rdata=0; write to same addr -> err=1, word 0 unchanged.
- Assert rst_ni=0 with 2 outstanding reads -> rvalid_o=0 immediately, no responses after release, next request granted normally with count=0.

Source files
------------

// File: rtl/ibex_data_mem_responder.sv
// Data-memory slave for the LSU data port: configurable grant delay, response
// latency and outstanding depth, in-order responses from an internal word array.
module ibex_data_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned GNT_DELAY       = 0,
    parameter int unsigned RSP_LATENCY     = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned WAIT_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] SPAN   = 33'(MEM_WORDS) * 33'd4;

    logic [31:0]            mem_q [MEM_WORDS];
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [OUT_W-1:0]       outst_q, outst_d;
    logic [RSP_LATENCY-1:0] vld_q, vld_d;
    logic [RSP_LATENCY-1:0] err_q, err_d;
    logic [31:0]            rdata_q [RSP_LATENCY];
    logic [31:0]            rdata_d [RSP_LATENCY];

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             retire;
    logic             accept;

    // BASE_ADDR is word aligned, so the byte offset compares correctly even
    // with nonzero addr[1:0]; those bits simply drop out of the index.
    assign off      = data_addr_i - BASE_ADDR;
    assign idx      = off[IDX_W+1:2];
    assign in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign retire   = vld_q[RSP_LATENCY-1];

    assign data_gnt_o = rst_ni & data_req_i & ~stall_i
                      & (32'(wait_cnt_q) >= GNT_DELAY)
                      & ((32'(outst_q) < MAX_OUTSTANDING) | retire);
    assign accept     = data_req_i & data_gnt_o;

    always_comb begin
        wait_cnt_d = '0;
        if (data_req_i && !data_gnt_o) begin
            wait_cnt_d = (32'(wait_cnt_q) < GNT_DELAY) ? wait_cnt_q + 1'b1 : wait_cnt_q;
        end

        outst_d = outst_q;
        if (accept && !retire) begin
            outst_d = outst_q + 1'b1;
        end else if (!accept && retire) begin
            outst_d = outst_q - 1'b1;
        end

        vld_d      = '0;
        err_d      = '0;
        vld_d[0]   = accept;
        err_d[0]   = accept & ~in_range;
        rdata_d[0] = (accept && in_range && !data_we_i) ? mem_q[idx] : '0;
        for (int unsigned i = 1; i < RSP_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
            outst_q    <= '0;
            vld_q      <= '0;
            err_q      <= '0;
            for (int unsigned i = 0; i < RSP_LATENCY; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            wait_cnt_q <= wait_cnt_d;
            outst_q    <= outst_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            for (int unsigned i = 0; i < RSP_LATENCY; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && data_we_i && in_range) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (data_be_i[n]) begin
                    mem_q[idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
                end
            end
        end
    end

    assign data_rvalid_o = retire;
    assign data_rdata_o  = retire ? rdata_q[RSP_LATENCY-1] : '0;
    assign data_err_o    = retire & err_q[RSP_LATENCY-1];

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Directed bench: default, GNT_DELAY=3 and RSP_LATENCY=3 instances of the responder.
module tb_ibex_data_mem_responder;

    logic clk = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // default instance
    logic        d_stall, d_req, d_gnt, d_we, d_rv, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    // GNT_DELAY = 3 instance
    logic        g_stall, g_req, g_gnt, g_we, g_rv, g_err;
    logic [3:0]  g_be;
    logic [31:0] g_addr, g_wdata, g_rdata;
    // RSP_LATENCY = 3 instance
    logic        l_stall, l_req, l_gnt, l_we, l_rv, l_err;
    logic [3:0]  l_be;
    logic [31:0] l_addr, l_wdata, l_rdata;

    ibex_data_mem_responder u_def (
        .clk(clk), .rst_ni(rst_ni), .stall_i(d_stall),
        .data_req_i(d_req), .data_gnt_o(d_gnt), .data_we_i(d_we), .data_be_i(d_be),
        .data_addr_i(d_addr), .data_wdata_i(d_wdata),
        .data_rvalid_o(d_rv), .data_rdata_o(d_rdata), .data_err_o(d_err)
    );

    ibex_data_mem_responder #(.GNT_DELAY(3)) u_gd (
        .clk(clk), .rst_ni(rst_ni), .stall_i(g_stall),
        .data_req_i(g_req), .data_gnt_o(g_gnt), .data_we_i(g_we), .data_be_i(g_be),
        .data_addr_i(g_addr), .data_wdata_i(g_wdata),
        .data_rvalid_o(g_rv), .data_rdata_o(g_rdata), .data_err_o(g_err)
    );

    ibex_data_mem_responder #(.RSP_LATENCY(3), .MAX_OUTSTANDING(2)) u_lat (
        .clk(clk), .rst_ni(rst_ni), .stall_i(l_stall),
        .data_req_i(l_req), .data_gnt_o(l_gnt), .data_we_i(l_we), .data_be_i(l_be),
        .data_addr_i(l_addr), .data_wdata_i(l_wdata),
        .data_rvalid_o(l_rv), .data_rdata_o(l_rdata), .data_err_o(l_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the default instance; check grant and the response visible this cycle.
    task automatic dstep(input string tag, input logic stall, input logic req, input logic we,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                         input logic eg, input logic erv, input logic [31:0] erd, input logic eer);
        d_stall = stall; d_req = req; d_we = we; d_addr = addr; d_be = be; d_wdata = wdata;
        #1;
        check({tag, ".gnt"}, 32'(d_gnt), 32'(eg));
        check({tag, ".rvalid"}, 32'(d_rv), 32'(erv));
        check({tag, ".rdata"}, d_rdata, erd);
        check({tag, ".err"}, 32'(d_err), 32'(eer));
        next_cycle();
    endtask

    // Read of out-of-range 0x1000 on the GNT_DELAY instance.
    task automatic gstep(input string tag, input logic req, input logic eg,
                         input logic erv, input logic eer);
        g_req = req;
        #1;
        check({tag, ".gnt"}, 32'(g_gnt), 32'(eg));
        check({tag, ".rvalid"}, 32'(g_rv), 32'(erv));
        check({tag, ".err"}, 32'(g_err), 32'(eer));
        check({tag, ".rdata"}, g_rdata, 32'h0);
        next_cycle();
    endtask

    // Four back-to-back requests with RSP_LATENCY=3, MAX_OUTSTANDING=2:
    // grants in cycles 0,1,3,4; responses in cycles 3,4,6,7.
    task automatic run4(input string tag, input logic we);
        logic [9:0] exp_gnt;
        logic [9:0] exp_rv;
        int unsigned iss;
        int unsigned rsp;
        exp_gnt = 10'b00_0001_1011;
        exp_rv  = 10'b00_1101_1000;
        iss = 0;
        rsp = 0;
        for (int c = 0; c < 10; c++) begin
            l_req   = (iss < 4);
            l_we    = we;
            l_be    = 4'hF;
            l_addr  = 32'h40 + 32'(4 * iss);
            l_wdata = 32'hA000_0000 + 32'(iss);
            #1;
            check($sformatf("%s.c%0d.gnt", tag, c), 32'(l_gnt), 32'(exp_gnt[c]));
            check($sformatf("%s.c%0d.rvalid", tag, c), 32'(l_rv), 32'(exp_rv[c]));
            check($sformatf("%s.c%0d.rdata", tag, c), l_rdata,
                  (exp_rv[c] && !we) ? 32'hA000_0000 + 32'(rsp) : 32'h0);
            check($sformatf("%s.c%0d.err", tag, c), 32'(l_err), 32'h0);
            if (exp_rv[c]) rsp++;
            if (exp_gnt[c]) iss++;
            next_cycle();
        end
        l_req = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        d_stall = 1'b0; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
        g_stall = 1'b0; g_req = 1'b0; g_we = 1'b0; g_be = 4'hF; g_addr = 32'h1000; g_wdata = '0;
        l_stall = 1'b0; l_req = 1'b0; l_we = 1'b0; l_be = 4'hF; l_addr = '0; l_wdata = '0;

        #2;
        check("rst.gnt", 32'(d_gnt), 32'h0);
        check("rst.rvalid", 32'(d_rv), 32'h0);
        check("rst.rdata", d_rdata, 32'h0);
        check("rst.err", 32'(d_err), 32'h0);
        d_req = 1'b0;
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // full write, read-after-write, partial write, be=0, out-of-range, top word, stall
        dstep("wr10",    0, 1, 1, 32'h10,   4'hF, 32'hDEAD_BEEF, 1, 0, 32'h0,         0);
        dstep("rd10",    0, 1, 0, 32'h10,   4'h0, 32'h0,         1, 1, 32'h0,         0);
        dstep("rsp10",   0, 0, 0, 32'h0,    4'h0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0);
        dstep("wr20",    0, 1, 1, 32'h20,   4'hF, 32'hDEAD_BEEF, 1, 0, 32'h0,         0);
        dstep("wr20p",   0, 1, 1, 32'h20,   4'h5, 32'h1122_3344, 1, 1, 32'h0,         0);
        dstep("rd20",    0, 1, 0, 32'h20,   4'hF, 32'h0,         1, 1, 32'h0,         0);
        dstep("rsp20",   0, 0, 0, 32'h0,    4'h0, 32'h0,         0, 1, 32'hDE22_BE44, 0);
        dstep("wrbe0",   0, 1, 1, 32'h10,   4'h0, 32'h5555_5555, 1, 0, 32'h0,         0);
        dstep("rdbe0",   0, 1, 0, 32'h10,   4'hF, 32'h0,         1, 1, 32'h0,         0);
        dstep("wr0",     0, 1, 1, 32'h0,    4'hF, 32'h0123_4567, 1, 1, 32'hDEAD_BEEF, 0);
        dstep("rdoor",   0, 1, 0, 32'h1000, 4'hF, 32'h0,         1, 1, 32'h0,         0);
        dstep("wroor",   0, 1, 1, 32'h1000, 4'hF, 32'hCAFE_F00D, 1, 1, 32'h0,         1);
        dstep("rd0",     0, 1, 0, 32'h0,    4'hF, 32'h0,         1, 1, 32'h0,         1);
        dstep("wrtop",   0, 1, 1, 32'hFFC,  4'hF, 32'h89AB_CDEF, 1, 1, 32'h0123_4567, 0);
        dstep("rdtop",   0, 1, 0, 32'hFFC,  4'hF, 32'h0,         1, 1, 32'h0,         0);
        dstep("stall",   1, 1, 0, 32'h0,    4'hF, 32'h0,         0, 1, 32'h89AB_CDEF, 0);
        dstep("idle",    0, 0, 0, 32'h0,    4'h0, 32'h0,         0, 0, 32'h0,         0);

        // GNT_DELAY=3: grant in 4th cycle of held req; wait counter clears after grant and on drop
        gstep("gd.h0", 1, 0, 0, 0);
        gstep("gd.h1", 1, 0, 0, 0);
        gstep("gd.h2", 1, 0, 0, 0);
        gstep("gd.h3", 1, 1, 0, 0);
        gstep("gd.post", 1, 0, 1, 1);
        gstep("gd.d0", 1, 0, 0, 0);
        gstep("gd.d1", 1, 0, 0, 0);
        gstep("gd.drop", 0, 0, 0, 0);
        gstep("gd.r0", 1, 0, 0, 0);
        gstep("gd.r1", 1, 0, 0, 0);
        gstep("gd.r2", 1, 0, 0, 0);
        gstep("gd.r3", 1, 1, 0, 0);
        gstep("gd.rsp", 0, 0, 1, 1);
        gstep("gd.end", 0, 0, 0, 0);

        // RSP_LATENCY=3, MAX_OUTSTANDING=2
        run4("lat.wr", 1'b1);
        run4("lat.rd", 1'b0);

        // reset with two reads in flight
        l_we = 1'b0; l_req = 1'b1; l_addr = 32'h40;
        #1;
        check("lr.g0", 32'(l_gnt), 32'h1);
        next_cycle();
        l_addr = 32'h44;
        #1;
        check("lr.g1", 32'(l_gnt), 32'h1);
        next_cycle();
        l_req = 1'b0;
        next_cycle();
        #1;
        check("lr.rv_before", 32'(l_rv), 32'h1);
        check("lr.rd_before", l_rdata, 32'hA000_0000);
        rst_ni = 1'b0;
        #1;
        check("lr.rv_async", 32'(l_rv), 32'h0);
        check("lr.rd_async", l_rdata, 32'h0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("lr.quiet%0d", c), 32'(l_rv), 32'h0);
            next_cycle();
        end
        run4("lat.post", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
